r2r_dac_wave_gen: RTL and testbench

Digital sample generator that produces the 8-bit code driving the on-chip R2R ladder DAC. It holds a small register file written over a byte-wide config port. A programmable prescaler sets the sample rate, and four waveform modes are provided: DC, sawtooth, triangle and square. Each new code is presented on a registered bus with a one-cycle update strobe. The block sits directly upstream of the R2R DAC; `code_out` connects to the ladder's bit inputs.

---
 rtl/r2r_dac_wave_gen.sv | 173 +++++++++++++++++
 tb/tb_r2r_dac_wave_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2r_dac_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : r2r_dac_wave_gen
// Description : Sample generator for the on-chip R2R ladder DAC. A byte-wide
//               config port writes four registers (MODE, DIV, STEP, LEVEL).
//               A prescaler paces samples at DIV+1 clocks each and the
//               selected waveform (DC, sawtooth, triangle, square) drives a
//               registered code bus with a one-cycle update strobe.
// Ports       : clk       - system clock
//               rst       - synchronous reset, active-high
//               cfg_addr  - register select (0 MODE, 1 DIV, 2 STEP, 3 LEVEL)
//               cfg_data  - register write data
//               cfg_wr    - register write strobe
//               code_out  - registered DAC code (to ladder bit inputs)
//               code_stb  - one-cycle pulse on each code_out update
// Revision    : 1.0 - initial release
// ============================================================================
module r2r_dac_wave_gen #(
    parameter int CODE_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_data,
    input  logic              cfg_wr,
    output logic [CODE_W-1:0] code_out,
    output logic              code_stb
);

    localparam logic [1:0] c_ADDR_MODE  = 2'd0;
    localparam logic [1:0] c_ADDR_DIV   = 2'd1;
    localparam logic [1:0] c_ADDR_STEP  = 2'd2;
    localparam logic [1:0] c_ADDR_LEVEL = 2'd3;

    localparam logic [1:0] c_WAVE_DC  = 2'd0;
    localparam logic [1:0] c_WAVE_SAW = 2'd1;
    localparam logic [1:0] c_WAVE_TRI = 2'd2;
    localparam logic [1:0] c_WAVE_SQR = 2'd3;

    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    localparam logic [CODE_W-1:0] c_PHASE_MAX = '1;

    // Register file. MODE keeps only its meaningful bits; the rest read as 0.
    logic              r_en;
    logic [1:0]        r_wave;
    logic [DIV_W-1:0]  r_div;
    logic [CODE_W-1:0] r_step;
    logic [CODE_W-1:0] r_level;

    // Generator state
    logic [DIV_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_phase;
    logic              r_dir;
    logic [CODE_W-1:0] r_code;
    logic              r_stb;

    logic              w_mode_wr;
    logic              w_tick;
    logic [CODE_W:0]   w_sum;
    logic [CODE_W-1:0] w_phase_nxt;
    logic              w_dir_nxt;
    logic [CODE_W-1:0] w_code_nxt;

    assign w_mode_wr = cfg_wr && (cfg_addr == c_ADDR_MODE);

    // A MODE write restarts the generator and suppresses any coincident tick.
    // The >= compare makes a DIV shrink below the live count tick at once.
    assign w_tick = r_en && (r_cnt >= r_div) && !w_mode_wr;

    // Carry-out kept so the triangle can detect reaching the top.
    assign w_sum = {1'b0, r_phase} + {1'b0, r_step};

    always_comb begin
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        w_code_nxt  = r_code;
        case (r_wave)
            c_WAVE_DC: begin
                w_code_nxt = r_level;
            end
            c_WAVE_SAW: begin
                w_phase_nxt = w_sum[CODE_W-1:0];
                w_code_nxt  = w_sum[CODE_W-1:0];
            end
            c_WAVE_TRI: begin
                if (r_dir == c_DIR_UP) begin
                    if (w_sum >= {1'b0, c_PHASE_MAX}) begin
                        w_phase_nxt = c_PHASE_MAX;
                        w_dir_nxt   = c_DIR_DOWN;
                    end else begin
                        w_phase_nxt = w_sum[CODE_W-1:0];
                    end
                end else begin
                    if (r_phase <= r_step) begin
                        w_phase_nxt = '0;
                        w_dir_nxt   = c_DIR_UP;
                    end else begin
                        w_phase_nxt = r_phase - r_step;
                    end
                end
                w_code_nxt = w_phase_nxt;
            end
            c_WAVE_SQR: begin
                w_phase_nxt = w_sum[CODE_W-1:0];
                w_code_nxt  = w_sum[CODE_W-1] ? r_level : '0;
            end
            default: begin
                w_code_nxt = r_code;
            end
        endcase
    end

    // Register writes land at the edge; the tick on that same edge still
    // sees the previous register values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_wave  <= c_WAVE_DC;
            r_div   <= '0;
            r_step  <= '0;
            r_level <= '0;
        end else if (cfg_wr) begin
            case (cfg_addr)
                c_ADDR_MODE: begin
                    r_en   <= cfg_data[7];
                    r_wave <= cfg_data[1:0];
                end
                c_ADDR_DIV:   r_div   <= cfg_data[DIV_W-1:0];
                c_ADDR_STEP:  r_step  <= cfg_data[CODE_W-1:0];
                c_ADDR_LEVEL: r_level <= cfg_data[CODE_W-1:0];
                default: begin
                    r_en <= r_en;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= '0;
            r_dir   <= c_DIR_UP;
            r_code  <= '0;
            r_stb   <= 1'b0;
        end else if (w_mode_wr) begin
            // code_out deliberately holds across a MODE write
            r_cnt   <= '0;
            r_phase <= '0;
            r_dir   <= c_DIR_UP;
            r_stb   <= 1'b0;
        end else if (!r_en) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= w_phase_nxt;
            r_dir   <= w_dir_nxt;
            r_code  <= w_code_nxt;
            r_stb   <= 1'b1;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
            r_stb <= 1'b0;
        end
    end

    assign code_out = r_code;
    assign code_stb = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_r2r_dac_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_r2r_dac_wave_gen
// Description : Self-checking bench for r2r_dac_wave_gen. Directed vector
//               table, hand-written corner sequences and randomized traffic
//               compared against a behavioural model of the generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r2r_dac_wave_gen;

    logic       clk;
    logic       rst;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_wr;
    logic [7:0] code_out;
    logic       code_stb;

    int checks;
    int errors;

    r2r_dac_wave_gen #(
        .CODE_W (8),
        .DIV_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_wr   (cfg_wr),
        .code_out (code_out),
        .code_stb (code_stb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Behavioural model: plain integer arithmetic on the register values
    // ------------------------------------------------------------------
    int m_en, m_wave, m_div, m_step, m_level;
    int m_cnt, m_phase, m_up, m_code, m_stb;

    task automatic model_edge(input int r, input int w, input int a, input int d);
        if (r != 0) begin
            m_en = 0; m_wave = 0; m_div = 0; m_step = 0; m_level = 0;
            m_cnt = 0; m_phase = 0; m_up = 1; m_code = 0; m_stb = 0;
            return;
        end
        if (w != 0 && a == 0) begin
            m_cnt = 0; m_phase = 0; m_up = 1; m_stb = 0;
        end else if (m_en == 0) begin
            m_cnt = 0; m_stb = 0;
        end else if (m_cnt >= m_div) begin
            m_cnt = 0;
            m_stb = 1;
            case (m_wave)
                0: m_code = m_level;
                1: begin
                    m_phase = (m_phase + m_step) % 256;
                    m_code  = m_phase;
                end
                2: begin
                    if (m_up != 0) begin
                        if (m_phase + m_step >= 255) begin
                            m_phase = 255; m_up = 0;
                        end else begin
                            m_phase = m_phase + m_step;
                        end
                    end else begin
                        if (m_phase <= m_step) begin
                            m_phase = 0; m_up = 1;
                        end else begin
                            m_phase = m_phase - m_step;
                        end
                    end
                    m_code = m_phase;
                end
                default: begin
                    m_phase = (m_phase + m_step) % 256;
                    m_code  = (m_phase >= 128) ? m_level : 0;
                end
            endcase
        end else begin
            m_cnt = m_cnt + 1;
            m_stb = 0;
        end
        // Writes take effect after the edge's own decisions
        if (w != 0) begin
            case (a)
                0: begin m_en = (d >> 7) & 1; m_wave = d & 3; end
                1: m_div = d;
                2: m_step = d;
                default: m_level = d;
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
    task automatic cycle(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
        rst      = r;
        cfg_wr   = w;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        model_edge(int'(r), int'(w), int'(a), int'(d));
        #1;
        chk("model_code", int'(code_out), m_code);
        chk("model_stb", int'(code_stb), m_stb);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       r;
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] code;
        logic       stb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic [7:0] code, input logic stb);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.code = code; v.stb = stb;
        tbl.push_back(v);
    endtask

    logic       rr, rw;
    logic [1:0] ra;
    logic [7:0] rd;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        cfg_wr   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 8'h00;
        m_en = 0; m_wave = 0; m_div = 0; m_step = 0; m_level = 0;
        m_cnt = 0; m_phase = 0; m_up = 1; m_code = 0; m_stb = 0;

        // reset state
        add(1, 0, 0, 8'h00, 8'h00, 0);
        // saw wrap: STEP=0x60 DIV=0 MODE=0x81
        add(0, 1, 2, 8'h60, 8'h00, 0);
        add(0, 1, 1, 8'h00, 8'h00, 0);
        add(0, 1, 0, 8'h81, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h60, 1);
        add(0, 0, 0, 8'h00, 8'hC0, 1);
        add(0, 0, 0, 8'h00, 8'h20, 1);
        add(0, 0, 0, 8'h00, 8'h80, 1);
        // STEP write on a tick edge: tick still uses old STEP 0x60
        add(0, 1, 2, 8'h70, 8'hE0, 1);
        // triangle saturation
        add(0, 1, 0, 8'h82, 8'hE0, 0);
        add(0, 0, 0, 8'h00, 8'h70, 1);
        add(0, 0, 0, 8'h00, 8'hE0, 1);
        add(0, 0, 0, 8'h00, 8'hFF, 1);
        add(0, 0, 0, 8'h00, 8'h8F, 1);
        add(0, 0, 0, 8'h00, 8'h1F, 1);
        add(0, 0, 0, 8'h00, 8'h00, 1);
        add(0, 0, 0, 8'h00, 8'h70, 1);
        // LEVEL/DIV writes on tick edges, then DC with DIV=3
        add(0, 1, 3, 8'h80, 8'hE0, 1);
        add(0, 1, 1, 8'h03, 8'hFF, 1);
        add(0, 1, 0, 8'h80, 8'hFF, 0);
        add(0, 0, 0, 8'h00, 8'hFF, 0);
        add(0, 0, 0, 8'h00, 8'hFF, 0);
        add(0, 0, 0, 8'h00, 8'hFF, 0);
        add(0, 0, 0, 8'h00, 8'h80, 1);
        add(0, 0, 0, 8'h00, 8'h80, 0);
        add(0, 0, 0, 8'h00, 8'h80, 0);
        add(0, 0, 0, 8'h00, 8'h80, 0);
        add(0, 0, 0, 8'h00, 8'h80, 1);
        // square: LEVEL=0xC8 STEP=0x40 DIV=1 MODE=0x83
        add(0, 1, 3, 8'hC8, 8'h80, 0);
        add(0, 1, 2, 8'h40, 8'h80, 0);
        add(0, 1, 1, 8'h01, 8'h80, 0);
        add(0, 1, 0, 8'h83, 8'h80, 0);
        add(0, 0, 0, 8'h00, 8'h80, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1);
        add(0, 0, 0, 8'h00, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'hC8, 1);
        add(0, 0, 0, 8'h00, 8'hC8, 0);
        add(0, 0, 0, 8'h00, 8'hC8, 1);
        add(0, 0, 0, 8'h00, 8'hC8, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1);
        // EN=0 freezes the output
        add(0, 1, 0, 8'h01, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0);
        // reset mid-saw with code 0x5A, rst beating a concurrent MODE write
        add(0, 1, 2, 8'h5A, 8'h00, 0);
        add(0, 1, 1, 8'h00, 8'h00, 0);
        add(0, 1, 0, 8'h81, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h5A, 1);
        add(1, 0, 0, 8'h00, 8'h00, 0);
        add(1, 1, 0, 8'h81, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d_code", i), int'(code_out), int'(tbl[i].code));
            chk($sformatf("vec%0d_stb", i), int'(code_stb), int'(tbl[i].stb));
        end

        // DIV shrunk below the live count ticks on the next edge
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 3, 8'h33);
        cycle(0, 1, 1, 8'd10);
        cycle(0, 1, 0, 8'h80);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 8'h00);
            chk("div_shrink_wait_stb", int'(code_stb), 0);
        end
        cycle(0, 1, 1, 8'd2);
        chk("div_shrink_wr_edge_stb", int'(code_stb), 0);
        cycle(0, 0, 0, 8'h00);
        chk("div_shrink_tick_stb", int'(code_stb), 1);
        chk("div_shrink_tick_code", int'(code_out), 8'h33);

        // MODE write on a tick edge: no strobe, phase restarts from 0
        cycle(0, 1, 2, 8'h10);
        cycle(0, 1, 1, 8'h00);
        cycle(0, 1, 0, 8'h81);
        cycle(0, 0, 0, 8'h00);
        chk("mode_tick_first", int'(code_out), 8'h10);
        cycle(0, 0, 0, 8'h00);
        chk("mode_tick_second", int'(code_out), 8'h20);
        cycle(0, 1, 0, 8'h81);
        chk("mode_tick_collide_stb", int'(code_stb), 0);
        chk("mode_tick_collide_code", int'(code_out), 8'h20);
        cycle(0, 0, 0, 8'h00);
        chk("mode_tick_restart_code", int'(code_out), 8'h10);
        chk("mode_tick_restart_stb", int'(code_stb), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 199) == 0);
            rw = ($urandom_range(0, 7) == 0);
            ra = 2'($urandom_range(0, 3));
            rd = 8'($urandom);
            if (ra == 2'd1 && $urandom_range(0, 3) != 0) rd = 8'($urandom_range(0, 4));
            if (ra == 2'd0 && $urandom_range(0, 3) != 0) rd[7] = 1'b1;
            cycle(rr, rw, ra, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
